// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, frame constants, divider helper.
// Also used by UART RX models and monitors.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // One requester's byte as seen through the grant mux.
    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } tx_item_t;

    // Clock cycles per bit; integer truncation, callers must keep the result >= 2.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side byte-stream bundle for the shared UART transmitter.
interface uart_tx_arb_if
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]   i_valid;
    logic [N_REQ*8-1:0] i_data;
    logic [N_REQ-1:0]   i_last;
    logic [N_REQ-1:0]   o_ready;
    logic [N_REQ-1:0]   o_gnt;

    modport master (
        output i_valid,
        output i_data,
        output i_last,
        input  o_ready,
        input  o_gnt
    );

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_last,
        output o_ready,
        output o_gnt
    );

endinterface

// File: rtl/uart_tx_ser.sv
// 8N1 serializer with integrated baud counter.
// Latency: o_txd falls the cycle after i_start; a frame lasts exactly 10*DIV cycles.
// Backpressure: i_start is ignored while o_busy is high; o_done marks the last stop-bit cycle.
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_txd,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_START = 2'(START);
    localparam logic [1:0] ST_DATA  = 2'(DATA);
    localparam logic [1:0] ST_STOP  = 2'(STOP);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        shreg   <= i_byte;
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    // bit_idx is reused to count stop bits
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_txd = 1'b1;
        case (state)
            ST_START: o_txd = 1'b0;
            ST_DATA:  o_txd = shreg[0];
            default:  o_txd = 1'b1;
        endcase
    end

    assign o_busy = (state != ST_IDLE);
    assign o_done = (state == ST_STOP) && bit_end && (bit_idx == LAST_STOP);

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter with packet lock sharing one 8N1 UART line among N_REQ byte streams.
// Latency: grant one cycle after a valid is seen, accept the next cycle, line start bit the cycle after.
// Backpressure: o_ready pulses once per byte, only while the serializer is idle and the requester holds the grant.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_tx_arb_if.slave  req,
    output logic          o_busy,
    output logic          o_txd
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr;
    logic [N_REQ-1:0] gnt;
    logic             last_q;

    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    tx_item_t         sel;
    logic [N_REQ-1:0] ready;
    logic             accept;
    logic             ser_busy;
    logic             ser_done;

    // Search upward from ptr first, then wrap to the indices below it.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!pick_vld && (PW'(j) >= ptr) && req.i_valid[j]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!pick_vld && (PW'(j) < ptr) && req.i_valid[j]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(j);
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel = '{dat: req.i_data[i*8 +: 8], last: req.i_last[i]};
            end
        end
    end

    assign ready  = ser_busy ? '0 : (gnt & req.i_valid);
    assign accept = |ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr    <= '0;
            gnt    <= '0;
            last_q <= 1'b0;
        end else if (gnt == '0) begin
            if (pick_vld) begin
                gnt <= N_REQ'(1) << pick_idx;
                ptr <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
        end else begin
            if (accept) begin
                last_q <= sel.last;
            end
            // Packet lock: release only after the last byte's stop bit.
            if (ser_done && last_q) begin
                gnt <= '0;
            end
        end
    end

    uart_tx_ser #(
        .DIV (DIV)
    ) u_ser (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (accept),
        .i_byte  (sel.dat),
        .o_txd   (o_txd),
        .o_busy  (ser_busy),
        .o_done  (ser_done)
    );

    assign req.o_ready = ready;
    assign req.o_gnt   = gnt;
    assign o_busy      = ser_busy;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed and randomized bench for uart_tx_arb: decodes the serial line and compares it to a packet-level arbitration model.
module tb_uart_tx_arb;

    localparam int N      = 4;
    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 10_000_000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int FRAME  = 10 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic txd;

    uart_tx_arb_if #(.N_REQ(N)) bus ();

    uart_tx_arb #(
        .N_REQ  (N),
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .req    (bus),
        .o_busy (busy),
        .o_txd  (txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dat;
        bit         last;
    } item_t;

    item_t        rq [N][$];
    bit           en [N];
    bit           rst_req;
    int           checks = 0;
    int           errors = 0;
    int           model_ptr;

    logic         tr_txd [$];
    logic         tr_busy[$];
    logic [N-1:0] tr_rdy [$];
    logic [N-1:0] tr_gnt [$];

    logic [7:0]   exp_b [$];
    bit           exp_first[$];
    logic [7:0]   dec_b [$];
    int           dec_s [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_trace();
        tr_txd.delete();
        tr_busy.delete();
        tr_rdy.delete();
        tr_gnt.delete();
    endtask

    // One clock: drive at negedge, sample 1 time unit later (the values the next posedge sees).
    task automatic step();
        @(negedge clk);
        rst = rst_req;
        for (int k = 0; k < N; k++) begin
            if (en[k] && rq[k].size() > 0) begin
                bus.i_valid[k]       = 1'b1;
                bus.i_data[8*k +: 8] = rq[k][0].dat;
                bus.i_last[k]        = rq[k][0].last;
            end else begin
                bus.i_valid[k]       = 1'b0;
                bus.i_data[8*k +: 8] = 8'($urandom);
                bus.i_last[k]        = 1'($urandom);
            end
        end
        #1;
        tr_txd.push_back(txd);
        tr_busy.push_back(busy);
        tr_rdy.push_back(bus.o_ready);
        tr_gnt.push_back(bus.o_gnt);
        chk("rdy_not_granted", 32'(bus.o_ready & ~bus.o_gnt), 0);
        chk("rdy_not_valid", 32'(bus.o_ready & ~bus.i_valid), 0);
        chk("rdy_onehot0", 32'($onehot0(bus.o_ready)), 1);
        chk("gnt_onehot0", 32'($onehot0(bus.o_gnt)), 1);
        if (!rst_req) begin
            for (int k = 0; k < N; k++) begin
                if (bus.o_ready[k]) void'(rq[k].pop_front());
            end
        end
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (rq[k].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input int limit, input string tag);
        bit done = 1'b0;
        int n = 0;
        while (!done && n < limit) begin
            step();
            n++;
            done = all_empty() && !busy && (bus.o_gnt == '0);
        end
        chk({tag, " drain"}, 32'(done), 1);
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        model_ptr = 0;
        clear_trace();
    endtask

    // Packet-level reference: round-robin from model_ptr, whole packets at a time.
    task automatic model();
        item_t cp [N][$];
        for (int k = 0; k < N; k++) cp[k] = rq[k];
        exp_b.delete();
        exp_first.delete();
        while (1) begin
            int found = -1;
            bit first = 1'b1;
            for (int o = 0; o < N; o++) begin
                int k = (model_ptr + o) % N;
                if (found < 0 && cp[k].size() > 0) found = k;
            end
            if (found < 0) break;
            while (cp[found].size() > 0) begin
                item_t it = cp[found].pop_front();
                exp_b.push_back(it.dat);
                exp_first.push_back(first);
                first = 1'b0;
                if (it.last) break;
            end
            model_ptr = (found + 1) % N;
        end
    endtask

    // Decode 8N1 frames from the sampled line, mid-bit sampling.
    task automatic decode();
        int i = 0;
        dec_b.delete();
        dec_s.delete();
        while (i + FRAME <= tr_txd.size()) begin
            if (tr_txd[i] === 1'b0) begin
                logic [7:0] b;
                for (int j = 0; j < 8; j++) b[j] = tr_txd[i + DIV/2 + DIV*(j+1)];
                chk("stop_bit", 32'(tr_txd[i + DIV/2 + 9*DIV]), 1);
                dec_b.push_back(b);
                dec_s.push_back(i);
                i = i + 9*DIV + DIV/2 + 1;
            end else begin
                i++;
            end
        end
    endtask

    task automatic cmp_stream(input string tag, input bit do_gap);
        decode();
        chk({tag, " count"}, 32'(dec_b.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < dec_b.size(); i++) begin
            chk($sformatf("%s byte%0d", tag, i), 32'(dec_b[i]), 32'(exp_b[i]));
            if (do_gap && i > 0)
                chk($sformatf("%s gap%0d", tag, i), 32'(dec_s[i] - dec_s[i-1]),
                    exp_first[i] ? 32'(FRAME + 2) : 32'(FRAME + 1));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int nrdy;
        int nbusy;
        int rd0;
        bit found;
        logic [7:0] v;
        logic exp_txd;

        bus.i_valid = '0;
        bus.i_data  = '0;
        bus.i_last  = '0;
        for (int k = 0; k < N; k++) en[k] = 1'b1;
        rst_req = 1'b1;
        repeat (3) step();
        rst_req = 1'b0;
        model_ptr = 0;
        clear_trace();

        // 1: idle after reset
        repeat (50) step();
        for (int c = 0; c < 50; c++)
            chk($sformatf("t1 idle c%0d", c), {22'd0, tr_txd[c], tr_busy[c], tr_gnt[c], tr_rdy[c]},
                {22'd0, 1'b1, 1'b0, 4'b0000, 4'b0000});

        // 2: single byte 0x55 from req0, exact waveform
        clear_trace();
        rq[0].push_back('{8'h55, 1'b1});
        model();
        drain(400, "t2");
        r = -1;
        nrdy = 0;
        nbusy = 0;
        for (int c = 0; c < tr_rdy.size(); c++) begin
            nrdy += $countones(tr_rdy[c]);
            if (tr_rdy[c][0]) r = c;
            if (tr_busy[c]) nbusy++;
        end
        chk("t2 ready pulses", 32'(nrdy), 1);
        chk("t2 busy cycles", 32'(nbusy), FRAME);
        if (r >= 0 && r + FRAME + 1 < tr_txd.size()) begin
            v = 8'h55;
            chk("t2 busy before", 32'(tr_busy[r]), 0);
            for (int c = 0; c < FRAME; c++) begin
                if (c < DIV) exp_txd = 1'b0;
                else if (c >= 9*DIV) exp_txd = 1'b1;
                else exp_txd = v[c/DIV - 1];
                chk($sformatf("t2 txd c%0d", c), 32'(tr_txd[r+1+c]), 32'(exp_txd));
                chk($sformatf("t2 busy c%0d", c), 32'(tr_busy[r+1+c]), 1);
            end
            chk("t2 txd after", 32'(tr_txd[r+1+FRAME]), 1);
            chk("t2 busy after", 32'(tr_busy[r+1+FRAME]), 0);
        end
        cmp_stream("t2", 1'b0);

        // 3: req1 and req2 contend with ptr=1; req1 has a second packet
        clear_trace();
        rq[1].push_back('{8'h41, 1'b1});
        rq[1].push_back('{8'h41, 1'b1});
        rq[2].push_back('{8'h42, 1'b1});
        model();
        drain(1000, "t3");
        cmp_stream("t3", 1'b1);

        // 4: packet lock, req3 waiting throughout req0's three-byte packet
        do_reset();
        rq[0].push_back('{8'h48, 1'b0});
        rq[0].push_back('{8'h49, 1'b0});
        rq[0].push_back('{8'h0A, 1'b1});
        rq[3].push_back('{8'h5A, 1'b1});
        model();
        drain(1000, "t4");
        cmp_stream("t4", 1'b1);

        // 5: reset at cycle 45 of a frame
        do_reset();
        rq[2].push_back('{8'hC3, 1'b1});
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            found = tr_rdy[tr_rdy.size()-1][2];
        end
        chk("t5 accepted", 32'(found), 1);
        repeat (45) step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("t5 txd after rst", 32'(txd), 1);
        chk("t5 gnt after rst", 32'(bus.o_gnt), 0);
        chk("t5 busy after rst", 32'(busy), 0);
        clear_trace();
        model_ptr = 0;
        rq[3].push_back('{8'h96, 1'b1});
        rq[1].push_back('{8'h69, 1'b1});
        model();
        drain(1000, "t5");
        r = -1;
        for (int c = 0; c < tr_gnt.size() && r < 0; c++) if (tr_gnt[c] != '0) r = c;
        if (r >= 0) chk("t5 first gnt", 32'(tr_gnt[r]), 32'h2);
        else chk("t5 gnt seen", 0, 1);
        cmp_stream("t5", 1'b1);

        // 6: granted req2 stalls mid-packet while req0 waits
        do_reset();
        rq[2].push_back('{8'hA5, 1'b0});
        rq[2].push_back('{8'h7E, 1'b1});
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            found = tr_rdy[tr_rdy.size()-1][2];
        end
        chk("t6 accepted", 32'(found), 1);
        en[2] = 1'b0;
        rq[0].push_back('{8'h33, 1'b1});
        rd0 = 0;
        for (int n = 0; n < 150; n++) begin
            step();
            chk($sformatf("t6 hold gnt n%0d", n), 32'(bus.o_gnt), 32'h4);
            if (bus.o_ready[0]) rd0++;
        end
        chk("t6 no ready0", 32'(rd0), 0);
        chk("t6 line idle", 32'(txd), 1);
        chk("t6 not busy", 32'(busy), 0);
        en[2] = 1'b1;
        drain(1000, "t6");
        exp_b = '{8'hA5, 8'h7E, 8'h33};
        exp_first = '{1'b1, 1'b0, 1'b1};
        cmp_stream("t6", 1'b0);
        model_ptr = 1;

        // Randomized packet mixes, some rounds without reset so the pointer carries over
        for (int rnd = 0; rnd < 6; rnd++) begin
            if (rnd % 2 == 0) do_reset();
            else clear_trace();
            for (int k = 0; k < N; k++) begin
                int npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    int nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++)
                        rq[k].push_back('{8'($urandom), (b == nb - 1)});
                end
            end
            if (all_empty()) rq[$urandom_range(0, N-1)].push_back('{8'($urandom), 1'b1});
            model();
            drain(4000, $sformatf("rnd%0d", rnd));
            cmp_stream($sformatf("rnd%0d", rnd), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Shares one 8N1 UART transmit line between N_REQ byte-stream requesters (CPU console, debug monitor, test sequencers) in the testbench/SoC debug path.
- Round-robin arbitration with packet lock, so one requester's message (e.g. a text line) is never interleaved with another's.
- Contains the baud generator and serializer.
- Its o_txd is the line a uart_rx_if-style monitor decodes.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLK_HZ, 100_000_000, clock frequency in Hz
BAUD, 115_200, line rate; DIV = CLK_HZ/BAUD, integer truncation, must be >= 2 (868 at defaults)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_valid  in  N_REQ  per-requester byte valid
i_data  in  N_REQ*8  per-requester byte; requester k uses bits [8k+7:8k]
i_last  in  N_REQ  byte is last of the requester's packet
o_ready  out  N_REQ  one-cycle accept strobe per requester
o_gnt  out  N_REQ  one-hot current grant; 0 when no grant held
o_busy  out  1  frame in progress
o_txd  out  1  serial line, idle high

Behaviour:
- Reset values: o_txd=1, o_ready=0, o_gnt=0, o_busy=0. Round-robin pointer=0, FSM=IDLE, baud counter=0, bit index=0.
- i_rst mid-frame: o_txd=1 from the next cycle, grant dropped, frame abandoned. A truncated frame on the line is acceptable.
- Arbitration, only when no grant is held:
  - Search i_valid starting at index ptr, wrapping modulo N_REQ.
  - The first set bit k becomes the grant; o_gnt=onehot(k) from the next cycle.
  - ptr := (k+1) mod N_REQ.
  - No valid: no grant, ptr unchanged.
- Packet lock:
  - Grant k is held across bytes until the byte with i_last[k]=1 completes its stop bit.
  - Grant is then released; arbitration runs in the following IDLE cycle.
  - Requester k dropping i_valid while granted: grant still held, line stays idle high.
- Handshake:
  - o_ready[k]=1 for exactly one cycle when FSM=IDLE, o_gnt[k]=1 and i_valid[k]=1.
  - In that cycle i_data and i_last of k are captured into the shift register and a last flag.
  - At most one o_ready bit set in any cycle; o_ready never set for a non-granted index.
- FSM (serializer):
  - IDLE -> START on accept.
  - START: o_txd=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each.
  - STOP: o_txd=1 for DIV cycles, then IDLE.
- Timing:
  - o_txd falls the cycle after the o_ready pulse. o_busy=1 from that cycle through the last STOP cycle.
  - Frame length is exactly 10*DIV cycles.
  - Back-to-back bytes in one packet: one IDLE cycle between the end of STOP and the next START.
  - New grant after packet end: one arbitration cycle plus one accept cycle before START, so inter-frame idle is 2 cycles.
- Widths:
  - Baud counter is clog2(DIV) bits and counts 0..DIV-1.
  - Bit index is 3 bits; no wrap beyond 7.
- Simultaneous events: all requesters valid -> strict rotation. i_valid changes during a frame do not affect the frame in flight.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - function calc_div(clk_hz, baud)
  - constants DATA_BITS=8, STOP_BITS=1
  - shared with UART RX models/monitors.
- One sub-module, uart_tx_ser:
  - Inputs: i_clk, i_rst, i_start, i_byte.
  - Outputs: o_txd, o_busy, o_done.
  - Contains the FSM and baud counter.
- The top level holds the arbiter, pointer, grant lock and mux.

Test Plan (CLK_HZ=100_000_000, BAUD=10_000_000 -> DIV=10):
1. Reset, no valid for 50 cycles -> o_txd=1, o_gnt=0, o_ready=0, o_busy=0 throughout.
2. Req0 sends 0x55 with last=1 -> one o_ready[0] pulse. o_txd: 10 cycles low, then 1,0,1,0,1,0,1,0 for 10 cycles each, then 10 high. o_busy high exactly 100 cycles. A uart_rx_if monitor at 10 Mbaud decodes rxd=55.
3. Req1 and req2 both hold single-byte last=1 packets (0x41, 0x42), ptr=1 after reset prep -> bytes on the line in order 0x41, 0x42, then 0x41 again if req1 is still valid.
4. Packet lock: req0 sends 0x48,0x49,0x0A with last on 0x0A while req3 is valid from cycle 0 -> req3 is not granted until after 0x0A's stop bit. Inter-byte idle is 1 cycle within the packet and 2 cycles before req3's start.
5. Assert i_rst for 1 cycle at cycle 45 of a frame -> o_txd=1 next cycle, o_gnt=0, o_busy=0. Next request starts a clean frame with arbitration from index 0.
6. Granted req2 drops i_valid after its first byte (last=0) while req0 is valid -> line idle, o_gnt stays 4'b0100, no o_ready[0]. Req2 then sends 0x7E with last=1 -> grant released, req0 served next.
